// File: rtl/bn_pass_controller.sv
// bn_pass_controller: sequences one batch-norm layer over a BRAM-resident
// feature map. MEAN and VAR stream every element to the BN datapath, a
// sqrt handshake sits between VAR and NORM, and NORM writes each datapath
// result back in place. The PS starts and acknowledges through ps_control.
module bn_pass_controller #(
    parameter int          HEIGHT    = 4,
    parameter int          WIDTH     = 4,
    parameter int          N         = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ps_control,
    output logic [31:0] pl_status,
    output logic [31:0] bram_addr,
    input  logic [31:0] bram_rddata,
    output logic [31:0] bram_wrdata,
    output logic [3:0]  bram_we,
    output logic [1:0]  dp_mode,
    output logic        dp_in_valid,
    input  logic        dp_in_ready,
    output logic [31:0] dp_in_data,
    output logic        dp_in_last,
    input  logic        dp_out_valid,
    output logic        dp_out_ready,
    input  logic [31:0] dp_out_data,
    output logic        sqrt_start,
    input  logic        sqrt_done
);
    localparam int TOTAL = N * HEIGHT * WIDTH;
    // One spare bit so the index can never wrap, even at TOTAL = 1.
    localparam int IDX_W = $clog2(TOTAL) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

    localparam logic [1:0] P_MEAN = 2'd0;
    localparam logic [1:0] P_VAR  = 2'd1;
    localparam logic [1:0] P_NORM = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE, S_RD, S_RD_WAIT, S_CAP, S_ISSUE,
        S_NORM_WAIT, S_WRITE, S_SQRT_REQ, S_SQRT_WAIT, S_DONE
    } state_t;

    state_t           state, state_n;
    logic [1:0]       pass;
    logic [IDX_W-1:0] idx;
    logic             start, busy, is_last;

    logic unused_ctrl;
    assign unused_ctrl = ^ps_control[31:1];

    assign start   = ps_control[0];
    assign busy    = (state != S_IDLE) && (state != S_DONE);
    assign is_last = (idx == LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    // Next state: element loop, pass sequencing, handshakes and abort
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:      if (start) state_n = S_RD;
            S_RD:        state_n = S_RD_WAIT;
            S_RD_WAIT:   state_n = S_CAP;
            S_CAP:       state_n = S_ISSUE;
            S_ISSUE: begin
                if (dp_in_ready) begin
                    if (pass == P_NORM)    state_n = S_NORM_WAIT;
                    else if (!is_last)     state_n = S_RD;
                    else if (pass == P_VAR) state_n = S_SQRT_REQ;
                    else                   state_n = S_RD;
                end
            end
            S_NORM_WAIT: if (dp_out_valid) state_n = S_WRITE;
            // An abort seen in WRITE still lets the write land, then idles.
            S_WRITE: begin
                if (!start)       state_n = S_IDLE;
                else if (is_last) state_n = S_DONE;
                else              state_n = S_RD;
            end
            S_SQRT_REQ:  state_n = S_SQRT_WAIT;
            S_SQRT_WAIT: if (sqrt_done) state_n = S_RD;
            S_DONE:      if (!start) state_n = S_IDLE;
            default:     state_n = S_IDLE;
        endcase
        if (busy && !start && state != S_WRITE) state_n = S_IDLE;
    end

    // Pass, index, address and data registers move only on state transitions
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pass        <= P_MEAN;
            idx         <= '0;
            bram_addr   <= '0;
            dp_in_data  <= '0;
            bram_wrdata <= '0;
        end else if (state_n == S_IDLE) begin
            pass <= P_MEAN;
            idx  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    pass      <= P_MEAN;
                    idx       <= '0;
                    bram_addr <= BASE_ADDR;
                end
                S_CAP: dp_in_data <= bram_rddata;
                S_ISSUE: begin
                    if (state_n == S_RD) begin
                        // Only MEAN can reach RD on its last element.
                        if (is_last) begin
                            pass      <= P_VAR;
                            idx       <= '0;
                            bram_addr <= BASE_ADDR;
                        end else begin
                            idx       <= idx + IDX_W'(1);
                            bram_addr <= bram_addr + 32'd4;
                        end
                    end
                end
                S_NORM_WAIT: if (state_n == S_WRITE) bram_wrdata <= dp_out_data;
                S_WRITE: begin
                    if (state_n == S_RD) begin
                        idx       <= idx + IDX_W'(1);
                        bram_addr <= bram_addr + 32'd4;
                    end
                end
                S_SQRT_WAIT: begin
                    if (state_n == S_RD) begin
                        pass      <= P_NORM;
                        idx       <= '0;
                        bram_addr <= BASE_ADDR;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from the current state
    always_comb begin
        dp_in_valid  = (state == S_ISSUE);
        dp_in_last   = (state == S_ISSUE) && is_last;
        dp_out_ready = (state == S_NORM_WAIT);
        bram_we      = (state == S_WRITE) ? 4'hf : 4'h0;
        sqrt_start   = (state == S_SQRT_REQ);
        dp_mode      = pass;
        pl_status    = {28'h0, (busy ? pass : 2'b00), busy, (state == S_DONE)};
    end

endmodule
